// File: rtl/mac_rx_dispatch.sv
// Ethernet RX front-end: preamble hunt, MAC header capture/filter, ethertype dispatch,
// FCS strip and CRC/length check. Define RX_STATS_EN to add frame statistics counters.
module mac_rx_dispatch #(
  parameter int                   NUM_CH    = 2,
  parameter logic [NUM_CH*16-1:0] CH_ETYPES = {16'h0806, 16'h0800},
  parameter int                   MAX_FRAME = 1518,
  parameter int                   MIN_FRAME = 64,
  parameter bit                   MCAST_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [7:0]        rx_data,
  input  logic [47:0]       local_mac_addr,
  input  logic              promisc,
  output logic [7:0]        ch_data,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [NUM_CH-1:0] ch_sof,
  output logic [NUM_CH-1:0] ch_eof,
  output logic              ch_err,
  output logic [47:0]       rx_dst_mac,
  output logic [47:0]       rx_src_mac,
  output logic [15:0]       rx_ethertype,
  output logic [15:0]       rx_frame_len
`ifdef RX_STATS_EN
  ,
  output logic [31:0]       stat_frames_ok,
  output logic [31:0]       stat_frames_err,
  output logic [31:0]       stat_frames_drop
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    DISCARD  = 3'd4
  } state_t;

  localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);
  localparam logic [15:0] OVER_LEN    = 16'(MAX_FRAME + 1);
  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Reflected CRC-32 (0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ 32'hEDB88320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_t              state_r, state_s;
  logic [2:0]          pre_cnt_r, pre_cnt_s;
  logic [15:0]         byte_cnt_r, byte_cnt_s, byte_inc_s;
  logic [31:0]         crc_r, crc_s, crc_upd_s;
  logic [103:0]        hdr_r, hdr_s;
  logic [111:0]        hdr_full_s;
  logic [31:0]         dl_r, dl_s;
  logic [2:0]          dl_cnt_r, dl_cnt_s;
  logic [NUM_CH-1:0]   ch_oh_r, ch_oh_s;
  logic [NUM_CH-1:0]   et_oh_s;
  logic                et_hit_s, filt_pass_s;
  logic [47:0]         dst_s;
  logic [7:0]          ch_data_r, ch_data_s;
  logic [NUM_CH-1:0]   ch_valid_r, ch_valid_s, ch_sof_r, ch_sof_s, ch_eof_r, ch_eof_s;
  logic                ch_err_r, ch_err_s;
  logic [47:0]         dst_mac_r, dst_mac_s, src_mac_r, src_mac_s;
  logic [15:0]         etype_r, etype_s, frame_len_r, frame_len_s;

  assign hdr_full_s  = {hdr_r, rx_data};
  assign dst_s       = hdr_full_s[111:64];
  assign crc_upd_s   = crc32_byte(crc_r, rx_data);
  assign byte_inc_s  = (byte_cnt_r == 16'hFFFF) ? byte_cnt_r : byte_cnt_r + 16'd1;
  assign filt_pass_s = (dst_s == local_mac_addr) || (&dst_s) || (MCAST_EN && dst_s[40]) || promisc;

  assign ch_data      = ch_data_r;
  assign ch_valid     = ch_valid_r;
  assign ch_sof       = ch_sof_r;
  assign ch_eof       = ch_eof_r;
  assign ch_err       = ch_err_r;
  assign rx_dst_mac   = dst_mac_r;
  assign rx_src_mac   = src_mac_r;
  assign rx_ethertype = etype_r;
  assign rx_frame_len = frame_len_r;

  // Ethertype lookup; walking downwards lets the lowest matching channel win.
  always_comb begin
    et_hit_s = 1'b0;
    et_oh_s  = {NUM_CH{1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (CH_ETYPES[16*k +: 16] == hdr_full_s[15:0]) begin
        et_hit_s    = 1'b1;
        et_oh_s     = {NUM_CH{1'b0}};
        et_oh_s[k]  = 1'b1;
      end else begin
        et_hit_s = et_hit_s;
      end
    end
  end

  // Next-state and next-output logic for the receive FSM.
  always_comb begin
    state_s     = state_r;
    pre_cnt_s   = pre_cnt_r;
    byte_cnt_s  = byte_cnt_r;
    crc_s       = crc_r;
    hdr_s       = hdr_r;
    dl_s        = dl_r;
    dl_cnt_s    = dl_cnt_r;
    ch_oh_s     = ch_oh_r;
    ch_data_s   = ch_data_r;
    ch_valid_s  = {NUM_CH{1'b0}};
    ch_sof_s    = {NUM_CH{1'b0}};
    ch_eof_s    = {NUM_CH{1'b0}};
    ch_err_s    = 1'b0;
    dst_mac_s   = dst_mac_r;
    src_mac_s   = src_mac_r;
    etype_s     = etype_r;
    frame_len_s = frame_len_r;
    case (state_r)
      IDLE: begin
        if (rx_dv && (rx_data == 8'h55)) begin
          state_s   = PREAMBLE;
          pre_cnt_s = 3'd1;
        end else if (rx_dv) begin
          state_s = DISCARD;
        end else begin
          state_s = IDLE;
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_s = IDLE;
        end else if (rx_data == 8'h55) begin
          if (pre_cnt_r == 3'd7) begin
            state_s = DISCARD;
          end else begin
            pre_cnt_s = pre_cnt_r + 3'd1;
          end
        end else if (rx_data == 8'hD5) begin
          state_s    = HEADER;
          byte_cnt_s = 16'd0;
          crc_s      = 32'hFFFFFFFF;
        end else begin
          state_s = DISCARD;
        end
      end
      HEADER: begin
        if (!rx_dv) begin
          state_s = IDLE;
        end else begin
          crc_s      = crc_upd_s;
          byte_cnt_s = byte_inc_s;
          hdr_s      = hdr_full_s[103:0];
          if (byte_cnt_r == 16'd13) begin
            if (filt_pass_s && et_hit_s) begin
              state_s   = PAYLOAD;
              dst_mac_s = hdr_full_s[111:64];
              src_mac_s = hdr_full_s[63:16];
              etype_s   = hdr_full_s[15:0];
              ch_oh_s   = et_oh_s;
              ch_sof_s  = et_oh_s;
              dl_cnt_s  = 3'd0;
            end else begin
              state_s = DISCARD;
            end
          end else begin
            state_s = HEADER;
          end
        end
      end
      PAYLOAD: begin
        if (!rx_dv) begin
          state_s     = IDLE;
          ch_eof_s    = ch_oh_r;
          ch_err_s    = (crc_r != CRC_RESIDUE) || (byte_cnt_r < MIN_LEN) || (dl_cnt_r != 3'd4);
          frame_len_s = byte_cnt_r;
        end else if (byte_cnt_r == MAX_LEN) begin
          // Oversize: this byte would be MAX_FRAME+1, so end the frame in place of a data strobe.
          state_s     = DISCARD;
          byte_cnt_s  = byte_inc_s;
          ch_eof_s    = ch_oh_r;
          ch_err_s    = 1'b1;
          frame_len_s = OVER_LEN;
        end else begin
          crc_s      = crc_upd_s;
          byte_cnt_s = byte_inc_s;
          dl_s       = {dl_r[23:0], rx_data};
          if (dl_cnt_r == 3'd4) begin
            ch_data_s  = dl_r[31:24];
            ch_valid_s = ch_oh_r;
          end else begin
            dl_cnt_s = dl_cnt_r + 3'd1;
          end
        end
      end
      DISCARD: begin
        if (!rx_dv) begin
          state_s = IDLE;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pre_cnt_r   <= 3'd0;
      byte_cnt_r  <= 16'd0;
      crc_r       <= 32'd0;
      hdr_r       <= 104'd0;
      dl_r        <= 32'd0;
      dl_cnt_r    <= 3'd0;
      ch_oh_r     <= {NUM_CH{1'b0}};
      ch_data_r   <= 8'd0;
      ch_valid_r  <= {NUM_CH{1'b0}};
      ch_sof_r    <= {NUM_CH{1'b0}};
      ch_eof_r    <= {NUM_CH{1'b0}};
      ch_err_r    <= 1'b0;
      dst_mac_r   <= 48'd0;
      src_mac_r   <= 48'd0;
      etype_r     <= 16'd0;
      frame_len_r <= 16'd0;
    end else begin
      state_r     <= state_s;
      pre_cnt_r   <= pre_cnt_s;
      byte_cnt_r  <= byte_cnt_s;
      crc_r       <= crc_s;
      hdr_r       <= hdr_s;
      dl_r        <= dl_s;
      dl_cnt_r    <= dl_cnt_s;
      ch_oh_r     <= ch_oh_s;
      ch_data_r   <= ch_data_s;
      ch_valid_r  <= ch_valid_s;
      ch_sof_r    <= ch_sof_s;
      ch_eof_r    <= ch_eof_s;
      ch_err_r    <= ch_err_s;
      dst_mac_r   <= dst_mac_s;
      src_mac_r   <= src_mac_s;
      etype_r     <= etype_s;
      frame_len_r <= frame_len_s;
    end
  end

`ifdef RX_STATS_EN
  logic drop_pend_r;
  logic ok_inc_s, err_inc_s, drop_inc_s;

  // A drop is charged when a frame leaves HEADER/PREAMBLE early, or leaves DISCARD it entered for a drop reason.
  always_comb begin
    ok_inc_s  = (|ch_eof_s) && !ch_err_s;
    err_inc_s = (|ch_eof_s) && ch_err_s;
    if (!rx_dv && ((state_r == PREAMBLE) || (state_r == HEADER) || ((state_r == DISCARD) && drop_pend_r))) begin
      drop_inc_s = 1'b1;
    end else begin
      drop_inc_s = 1'b0;
    end
  end

  // Statistics counters, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pend_r      <= 1'b0;
      stat_frames_ok   <= 32'd0;
      stat_frames_err  <= 32'd0;
      stat_frames_drop <= 32'd0;
    end else begin
      if ((state_s == DISCARD) && (state_r != DISCARD)) begin
        drop_pend_r <= (state_r != PAYLOAD);
      end else if ((state_r == DISCARD) && !rx_dv) begin
        drop_pend_r <= 1'b0;
      end else begin
        drop_pend_r <= drop_pend_r;
      end
      if (ok_inc_s && (stat_frames_ok != 32'hFFFFFFFF)) begin
        stat_frames_ok <= stat_frames_ok + 32'd1;
      end else begin
        stat_frames_ok <= stat_frames_ok;
      end
      if (err_inc_s && (stat_frames_err != 32'hFFFFFFFF)) begin
        stat_frames_err <= stat_frames_err + 32'd1;
      end else begin
        stat_frames_err <= stat_frames_err;
      end
      if (drop_inc_s && (stat_frames_drop != 32'hFFFFFFFF)) begin
        stat_frames_drop <= stat_frames_drop + 32'd1;
      end else begin
        stat_frames_drop <= stat_frames_drop;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_rx_dispatch.sv
// Scoreboard bench for mac_rx_dispatch: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_mac_rx_dispatch;

  localparam int K_RESET = 0;
  localparam int K_EMPTY = 1;
  localparam int K_STATS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [47:0] local_mac_addr = 48'h000A3501FEC0;
  logic        promisc = 1'b0;
  logic [7:0]  ch_data;
  logic [1:0]  ch_valid, ch_sof, ch_eof;
  logic        ch_err;
  logic [47:0] rx_dst_mac, rx_src_mac;
  logic [15:0] rx_ethertype, rx_frame_len;
`ifdef RX_STATS_EN
  logic [31:0] stat_frames_ok, stat_frames_err, stat_frames_drop;
  int          exp_ok = 0, exp_err = 0, exp_drop = 0;
`endif

  mac_rx_dispatch dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data),
    .local_mac_addr(local_mac_addr), .promisc(promisc),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_sof(ch_sof), .ch_eof(ch_eof), .ch_err(ch_err),
    .rx_dst_mac(rx_dst_mac), .rx_src_mac(rx_src_mac), .rx_ethertype(rx_ethertype),
    .rx_frame_len(rx_frame_len)
`ifdef RX_STATS_EN
    , .stat_frames_ok(stat_frames_ok), .stat_frames_err(stat_frames_err),
    .stat_frames_drop(stat_frames_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [1:0]  ch;
    logic [7:0]  data;
    logic        err;
    logic [15:0] len;
    logic [15:0] etype;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          chk_req = 0;
  int          chk_ack = 0;
  int          chk_kind = 0;
  int          mon_n;
  int          got_kind;
  logic [1:0]  got_ch;
  logic [7:0]  fb[0:1599];
  int          fl;

  // Monitor: every strobe pops one expectation; also serves check requests from the stimulus thread.
  always @(negedge clk) begin
    mon_n = $countones(ch_sof) + $countones(ch_valid) + $countones(ch_eof);
    if (mon_n != 0) begin
      checks++;
      got_kind = (|ch_sof) ? 0 : ((|ch_valid) ? 1 : 2);
      got_ch   = ch_sof | ch_valid | ch_eof;
      if (mon_n != 1) begin
        failures++;
        $display("FAIL strobe_exclusive sof=%b valid=%b eof=%b required exactly one strobe bit", ch_sof, ch_valid, ch_eof);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe kind=%0d ch=%b data=%h required no strobe", got_kind, got_ch, ch_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ((got_kind != mon_e.kind) || (got_ch != mon_e.ch) ||
            ((mon_e.kind == 0) && (rx_ethertype != mon_e.etype)) ||
            ((mon_e.kind == 1) && (ch_data != mon_e.data)) ||
            ((mon_e.kind == 2) && ((ch_err != mon_e.err) || (rx_frame_len != mon_e.len)))) begin
          failures++;
          $display("FAIL strobe_kind%0d got kind=%0d ch=%b data=%h err=%b len=%0d etype=%h required kind=%0d ch=%b data=%h err=%b len=%0d etype=%h",
                   mon_e.kind, got_kind, got_ch, ch_data, ch_err, rx_frame_len, rx_ethertype,
                   mon_e.kind, mon_e.ch, mon_e.data, mon_e.err, mon_e.len, mon_e.etype);
        end
      end
    end
    if (chk_req != chk_ack) begin
      checks++;
      case (chk_kind)
        K_RESET: begin
          if ({ch_data, ch_valid, ch_sof, ch_eof, ch_err, rx_dst_mac, rx_src_mac, rx_ethertype, rx_frame_len} != 187'd0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h valid=%b sof=%b eof=%b err=%b dst=%h src=%h et=%h len=%0d required all zero",
                     ch_data, ch_valid, ch_sof, ch_eof, ch_err, rx_dst_mac, rx_src_mac, rx_ethertype, rx_frame_len);
          end
        end
        K_EMPTY: begin
          if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
            exp_q.delete();
          end
        end
`ifdef RX_STATS_EN
        K_STATS: begin
          if ((stat_frames_ok != 32'(exp_ok)) || (stat_frames_err != 32'(exp_err)) || (stat_frames_drop != 32'(exp_drop))) begin
            failures++;
            $display("FAIL stats got ok=%0d err=%0d drop=%0d required ok=%0d err=%0d drop=%0d",
                     stat_frames_ok, stat_frames_err, stat_frames_drop, exp_ok, exp_err, exp_drop);
          end
        end
`endif
        default: begin
          failures++;
          $display("FAIL check_kind got %0d required known kind", chk_kind);
        end
      endcase
      chk_ack = chk_req;
    end
  end

  task automatic req(input int kind);
    chk_kind = kind;
    chk_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic r);
    @(negedge clk);
    rx_dv   = dv;
    rx_data = d;
    rst     = r;
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input int plen, input int seed);
    logic [47:0] src;
    logic [31:0] c;
    src = 48'h001122334455;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dst[47 - 8*i -: 8];
      fb[6 + i] = src[47 - 8*i -: 8];
    end
    fb[12] = et[15:8];
    fb[13] = et[7:0];
    for (int i = 0; i < plen; i++) fb[14 + i] = 8'((i * 7 + seed) & 255);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 14 + plen; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ fb[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fb[14 + plen + i] = c[8*i +: 8];
    fl = 18 + plen;
  endtask

  task automatic push(input int kind, input logic [1:0] ch, input logic [7:0] d, input logic err,
                      input logic [15:0] len, input logic [15:0] et);
    exp_t e;
    e.kind = kind; e.ch = ch; e.data = d; e.err = err; e.len = len; e.etype = et;
    exp_q.push_back(e);
  endtask

  // Expect a delivered frame: sof, nemit payload bytes, then optionally eof.
  task automatic expect_frame(input logic [1:0] ch, input logic [15:0] et, input int nemit,
                              input logic err, input logic [15:0] len, input bit has_eof);
    push(0, ch, 8'd0, 1'b0, 16'd0, et);
    for (int i = 0; i < nemit; i++) push(1, ch, fb[14 + i], 1'b0, 16'd0, 16'd0);
    if (has_eof) push(2, ch, 8'd0, err, len, 16'd0);
  endtask

  task automatic send(input int npre, input int rst_at);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < fl; i++) begin
      drive(1'b1, fb[i], (i == rst_at));
      if ((rst_at >= 0) && (i == rst_at + 1)) req(K_RESET);
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 8'd0, 1'b0);
    req(K_EMPTY);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) drive(1'b0, 8'd0, 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    req(K_RESET);

    build(48'hFFFFFFFFFFFF, 16'h0806, 46, 3);
    expect_frame(2'b10, 16'h0806, 46, 1'b0, 16'd64, 1'b1);
    send(7, -1);

    build(48'h000A3501FEC0, 16'h0800, 46, 9);
    fb[fl - 1] = fb[fl - 1] ^ 8'hFF;
    expect_frame(2'b01, 16'h0800, 46, 1'b1, 16'd64, 1'b1);
    send(7, -1);

    build(48'h000A3501FEC1, 16'h0800, 46, 5);
    send(7, -1);
`ifdef RX_STATS_EN
    exp_ok = 1; exp_err = 1; exp_drop = 1;
    req(K_STATS);
`endif

    promisc = 1'b1;
    expect_frame(2'b01, 16'h0800, 46, 1'b0, 16'd64, 1'b1);
    send(7, -1);
    promisc = 1'b0;

    build(48'hFFFFFFFFFFFF, 16'h86DD, 46, 1);
    send(7, -1);

    build(48'hFFFFFFFFFFFF, 16'h0806, 46, 2);
    send(8, -1);

    build(48'hFFFFFFFFFFFF, 16'h0806, 10, 4);
    expect_frame(2'b10, 16'h0806, 10, 1'b1, 16'd28, 1'b1);
    send(7, -1);

    build(48'hFFFFFFFFFFFF, 16'h0800, 2, 6);
    fl = 16;
    expect_frame(2'b01, 16'h0800, 0, 1'b1, 16'd16, 1'b1);
    send(7, -1);

    build(48'h000A3501FEC0, 16'h0800, 1582, 11);
    expect_frame(2'b01, 16'h0800, 1500, 1'b1, 16'd1519, 1'b1);
    send(7, -1);

    build(48'h000A3501FEC0, 16'h0800, 1500, 13);
    expect_frame(2'b01, 16'h0800, 1500, 1'b0, 16'd1518, 1'b1);
    send(7, -1);
`ifdef RX_STATS_EN
    exp_ok = 3; exp_err = 4; exp_drop = 3;
    req(K_STATS);
`endif

    build(48'hFFFFFFFFFFFF, 16'h0806, 46, 17);
    expect_frame(2'b10, 16'h0806, 16, 1'b0, 16'd0, 1'b0);
    send(7, 34);

    build(48'hFFFFFFFFFFFF, 16'h0806, 46, 21);
    expect_frame(2'b10, 16'h0806, 46, 1'b0, 16'd64, 1'b1);
    send(7, -1);
`ifdef RX_STATS_EN
    exp_ok = 1; exp_err = 0; exp_drop = 1;
    req(K_STATS);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
